// File: rtl/line_window_engine.sv
// line_window_engine: rotating bank of KSIZE+1 line buffers emitting KSIZE x KSIZE pixel windows on a ready/valid port.
// Optional macro WINDOW_HPAD_EN: zero-padded, column-centred windows (LINE_WIDTH windows per line).
module line_window_engine #(
  parameter int unsigned LINE_WIDTH = 512,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KSIZE      = 3
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_valid,
  input  logic [DATA_WIDTH-1:0]             i_data,
  output logic                              o_ready,
  input  logic                              i_ready,
  output logic [KSIZE*KSIZE*DATA_WIDTH-1:0] o_data,
  output logic                              o_valid,
  output logic                              o_intr
);
  localparam int unsigned NUM_LB = KSIZE + 1;
`ifdef WINDOW_HPAD_EN
  localparam int unsigned HALF    = (KSIZE - 1) / 2;
  localparam int unsigned RD_COLS = LINE_WIDTH + 2 * HALF;
`else
  localparam int unsigned RD_COLS = LINE_WIDTH;
`endif
  localparam int unsigned WC_W   = $clog2(LINE_WIDTH);
  localparam int unsigned RC_W   = $clog2(RD_COLS);
  localparam int unsigned SEL_W  = $clog2(NUM_LB);
  localparam int unsigned FILL_W = $clog2(NUM_LB + 1);
  localparam int unsigned WIN_W  = KSIZE * KSIZE * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_LINE_END} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [NUM_LB][LINE_WIDTH];
  logic [WC_W-1:0]       r_wr_col;
  logic [SEL_W-1:0]      r_wr_sel, r_rd_sel;
  logic [FILL_W-1:0]     r_filled;
  logic [RC_W-1:0]       r_rd_col;
  logic                  r_ready, r_intr, r_col_vld, r_col_win;
  logic [DATA_WIDTH-1:0] r_col_data [KSIZE];
  logic [DATA_WIDTH-1:0] r_win [KSIZE][KSIZE-1];
  logic [WIN_W-1:0]      r_out_data, r_skid_data;
  logic                  r_out_vld, r_skid_vld;

  logic                  w_accept, w_wr_wrap, w_issue, w_line_end, w_push, w_pop, w_room;
  logic [FILL_W-1:0]     w_filled_nxt;
  logic [2:0]            w_occ_nxt;
  logic [SEL_W-1:0]      w_row_sel [KSIZE];
  logic [WC_W-1:0]       w_rd_addr;
  logic [WIN_W-1:0]      w_win;

  assign w_accept     = i_valid && r_ready;
  assign w_wr_wrap    = w_accept && (r_wr_col == WC_W'(LINE_WIDTH - 1));
  assign w_filled_nxt = r_filled + FILL_W'(w_wr_wrap) - FILL_W'(w_line_end);

  // Issue only if the skid stage is guaranteed a free slot when the read data lands.
  assign w_push    = r_col_vld && r_col_win;
  assign w_pop     = r_out_vld && i_ready;
  assign w_occ_nxt = 3'(r_out_vld) + 3'(r_skid_vld) + 3'(w_push) - 3'(w_pop);
  assign w_room    = (w_occ_nxt <= 3'd1);

`ifdef WINDOW_HPAD_EN
  logic w_pad;
  assign w_pad     = (r_rd_col < RC_W'(HALF)) || (r_rd_col >= RC_W'(LINE_WIDTH + HALF));
  assign w_rd_addr = WC_W'(r_rd_col - RC_W'(HALF));
`else
  assign w_rd_addr = r_rd_col;
`endif

  always_comb begin
    for (int unsigned r = 0; r < KSIZE; r++) begin
      if (32'(r_rd_sel) + r >= NUM_LB) w_row_sel[r] = SEL_W'(32'(r_rd_sel) + r - NUM_LB);
      else                             w_row_sel[r] = SEL_W'(32'(r_rd_sel) + r);
    end
  end

  always_comb begin
    w_win = '0;
    for (int unsigned r = 0; r < KSIZE; r++) begin
      for (int unsigned c = 0; c < KSIZE - 1; c++)
        w_win[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH] = r_win[r][c];
      w_win[(r*KSIZE+KSIZE-1)*DATA_WIDTH +: DATA_WIDTH] = r_col_data[r];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_line_end  = 1'b0;
    case (r_state)
      S_IDLE: if (r_filled >= FILL_W'(KSIZE)) w_state_nxt = S_READ;
      S_READ: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (r_rd_col == RC_W'(RD_COLS - 1)) w_state_nxt = S_LINE_END;
        end
      end
      S_LINE_END: begin
        w_line_end  = 1'b1;
        w_state_nxt = (r_filled - FILL_W'(1) >= FILL_W'(KSIZE)) ? S_READ : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) r_mem[r_wr_sel][r_wr_col] <= i_data;
  end

  // Column read across the held buffers; padded columns come back as zero.
  always_ff @(posedge i_clk) begin
    if (w_issue) begin
      for (int unsigned r = 0; r < KSIZE; r++) begin
`ifdef WINDOW_HPAD_EN
        r_col_data[r] <= w_pad ? '0 : r_mem[w_row_sel[r]][w_rd_addr];
`else
        r_col_data[r] <= r_mem[w_row_sel[r]][w_rd_addr];
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_col_vld) begin
      for (int unsigned r = 0; r < KSIZE; r++) begin
        for (int unsigned c = 0; c < KSIZE - 2; c++) r_win[r][c] <= r_win[r][c+1];
        r_win[r][KSIZE-2] <= r_col_data[r];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_col    <= '0;
      r_wr_sel    <= '0;
      r_rd_sel    <= '0;
      r_filled    <= '0;
      r_rd_col    <= '0;
      r_ready     <= 1'b0;
      r_intr      <= 1'b0;
      r_col_vld   <= 1'b0;
      r_col_win   <= 1'b0;
      r_out_data  <= '0;
      r_out_vld   <= 1'b0;
      r_skid_data <= '0;
      r_skid_vld  <= 1'b0;
    end else begin
      if (w_accept) r_wr_col <= w_wr_wrap ? '0 : r_wr_col + WC_W'(1);
      if (w_wr_wrap) r_wr_sel <= (r_wr_sel == SEL_W'(NUM_LB - 1)) ? '0 : r_wr_sel + SEL_W'(1);
      if (w_line_end) r_rd_sel <= (r_rd_sel == SEL_W'(NUM_LB - 1)) ? '0 : r_rd_sel + SEL_W'(1);
      r_filled <= w_filled_nxt;
      r_ready  <= (w_filled_nxt < FILL_W'(NUM_LB));
      r_intr   <= (w_state_nxt == S_LINE_END);
      if (w_issue) r_rd_col <= (r_rd_col == RC_W'(RD_COLS - 1)) ? '0 : r_rd_col + RC_W'(1);
      r_col_vld <= w_issue;
      r_col_win <= w_issue && (r_rd_col >= RC_W'(KSIZE - 1));
      // Two-entry skid: output register backed by one spare slot.
      if (w_push && (!r_out_vld || w_pop)) begin
        if (r_skid_vld) begin
          r_out_data  <= r_skid_data;
          r_skid_data <= w_win;
        end else begin
          r_out_data <= w_win;
        end
        r_out_vld <= 1'b1;
      end else if (w_push) begin
        r_skid_data <= w_win;
        r_skid_vld  <= 1'b1;
      end else if (w_pop) begin
        if (r_skid_vld) begin
          r_out_data <= r_skid_data;
          r_skid_vld <= 1'b0;
        end else begin
          r_out_vld <= 1'b0;
        end
      end
    end
  end

  assign o_ready = r_ready;
  assign o_data  = r_out_data;
  assign o_valid = r_out_vld;
  assign o_intr  = r_intr;
endmodule

// File: tb/tb_line_window_engine.sv
// Directed bench for line_window_engine (LINE_WIDTH=8, KSIZE=3); honours WINDOW_HPAD_EN when defined.
module tb_line_window_engine;
  localparam int LW = 8;
  localparam int DW = 8;
  localparam int K  = 3;
  localparam int WW = K * K * DW;
`ifdef WINDOW_HPAD_EN
  localparam int WPL  = LW;
  localparam int PADC = (K - 1) / 2;
`else
  localparam int WPL  = LW - K + 1;
  localparam int PADC = 0;
`endif

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_ready;
  logic          i_ready = 1'b0;
  logic [WW-1:0] o_data;
  logic          o_valid;
  logic          o_intr;

  line_window_engine #(.LINE_WIDTH(LW), .DATA_WIDTH(DW), .KSIZE(K)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_intr(o_intr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int intr_cnt = 0;
  int intr_cyc = 0;
  int hs_cyc = 0;
  bit rdy_mode = 1'b0;
  bit rdy_const = 1'b1;
  logic [WW-1:0] got[$];
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_data = '0;

  typedef struct {
    int          win;
    int          r;
    int          c;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic logic [WW-1:0] exp_win(input int top, input int n, input int off);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        int col;
        col = n + c - PADC;
        if (col >= 0 && col < LW) w[(r*K+c)*DW +: DW] = DW'(off + (top + r) * 16 + col);
      end
    end
    return w;
  endfunction

  // i_ready driver: changes just after the rising edge
  initial forever begin
    @(posedge clk);
    #1;
    i_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_const;
  end

  // output monitor: records handshakes, o_intr pulses and checks stall stability
  initial forever begin
    @(posedge clk);
    cyc++;
    #3;
    if (i_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", WW'(o_valid), WW'(1));
        check("hold_data", o_data, prev_data);
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      if (o_valid && i_ready) begin
        got.push_back(o_data);
        hs_cyc = cyc;
      end
      if (o_intr) begin
        intr_cnt++;
        intr_cyc = cyc;
      end
    end
  end

  task automatic do_reset(input string name);
    @(negedge clk);
    i_reset = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #3;
    check({name, "_valid"}, WW'(o_valid), '0);
    check({name, "_data"}, o_data, '0);
    check({name, "_intr"}, WW'(o_intr), '0);
    check({name, "_ready"}, WW'(o_ready), '0);
    @(negedge clk);
    i_reset = 1'b0;
    @(posedge clk);
    #3;
    check({name, "_ready_up"}, WW'(o_ready), WW'(1));
    @(negedge clk);
    got.delete();
    intr_cnt = 0;
  endtask

  task automatic send_pixel(input logic [DW-1:0] d);
    int g;
    g = 0;
    i_valid = 1'b1;
    i_data  = d;
    while (!o_ready && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) timeout_fail("send_pixel");
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic send_lines(input int nrows, input int off);
    for (int row = 0; row < nrows; row++)
      for (int col = 0; col < LW; col++) send_pixel(DW'(off + row * 16 + col));
  endtask

  task automatic wait_windows(input int n, input int budget);
    int g;
    g = 0;
    while (got.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (got.size() < n) timeout_fail("wait_windows");
  endtask

  task automatic check_seq(input string name, input int ngrp, input int off);
    check({name, "_count"}, WW'(got.size()), WW'(ngrp * WPL));
    for (int i = 0; i < ngrp * WPL && i < got.size(); i++)
      check({name, "_win"}, got[i], exp_win(i / WPL, i % WPL, off));
  endtask

  initial begin
    int acc;
    int g;
    logic [WW-1:0] w;
`ifdef WINDOW_HPAD_EN
    tbl[0] = '{0, 0, 0, 8'h00}; tbl[1] = '{0, 0, 1, 8'h00}; tbl[2] = '{0, 0, 2, 8'h01};
    tbl[3] = '{7, 2, 0, 8'h26}; tbl[4] = '{7, 2, 1, 8'h27}; tbl[5] = '{7, 2, 2, 8'h00};
    tbl[6] = '{3, 1, 1, 8'h13};
`else
    tbl[0] = '{0, 0, 0, 8'h00}; tbl[1] = '{0, 0, 1, 8'h01}; tbl[2] = '{0, 0, 2, 8'h02};
    tbl[3] = '{0, 2, 0, 8'h20}; tbl[4] = '{0, 2, 2, 8'h22}; tbl[5] = '{5, 1, 0, 8'h15};
    tbl[6] = '{5, 1, 2, 8'h17};
`endif
    repeat (2) @(posedge clk);

    // 1: three lines at full rate
    rdy_mode = 1'b0; rdy_const = 1'b1;
    do_reset("rst1");
    send_lines(3, 0);
    wait_windows(WPL, 300);
    repeat (20) @(negedge clk);
    check_seq("t1", 1, 0);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].win < got.size()) begin
        w = got[tbl[i].win];
        check("t1_tbl", WW'(w[(tbl[i].r*K+tbl[i].c)*DW +: DW]), WW'(tbl[i].exp));
      end else begin
        timeout_fail("t1_tbl_missing");
      end
    end
    check("t1_intr_cnt", WW'(intr_cnt), WW'(1));
    check("t1_intr_to_last", WW'(hs_cyc - intr_cyc), WW'(1));

    // 2: same stream with random backpressure
    do_reset("rst2");
    rdy_mode = 1'b1;
    send_lines(3, 0);
    wait_windows(WPL, 600);
    repeat (30) @(negedge clk);
    rdy_mode = 1'b0;
    repeat (5) @(negedge clk);
    check_seq("t2", 1, 0);
    check("t2_intr_cnt", WW'(intr_cnt), WW'(1));

    // 3: no downstream ready, continuous input until the bank is full
    rdy_const = 1'b0;
    do_reset("rst3");
    acc = 0;
    for (int k = 0; k < 80; k++) begin
      i_valid = 1'b1;
      i_data  = DW'((acc / LW) * 16 + acc % LW);
      if (o_ready) acc++;
      @(negedge clk);
    end
    i_valid = 1'b0;
    check("t3_accepted", WW'(acc), WW'(32));
    check("t3_ready_low", WW'(o_ready), '0);
    check("t3_no_output", WW'(got.size()), '0);
    rdy_const = 1'b1;
    g = 0;
    while (intr_cnt < 1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (intr_cnt < 1) timeout_fail("t3_intr");
    @(posedge clk);
    #3;
    check("t3_ready_back", WW'(o_ready), WW'(1));
    @(negedge clk);
    wait_windows(2 * WPL, 300);
    repeat (20) @(negedge clk);
    check_seq("t3", 2, 0);
    check("t3_intr_cnt", WW'(intr_cnt), WW'(2));

    // 4: six lines at full rate; line completions overlap line-end cycles
    do_reset("rst4");
    send_lines(6, 0);
    wait_windows(4 * WPL, 800);
    repeat (20) @(negedge clk);
    check_seq("t4", 4, 0);
    check("t4_intr_cnt", WW'(intr_cnt), WW'(4));

    // 5: reset during the second line group's read, then a fresh stream
    do_reset("rst5a");
    send_lines(4, 0);
    wait_windows(WPL + 2, 400);
    do_reset("rst5b");
    send_lines(3, 8'h40);
    wait_windows(WPL, 300);
    repeat (20) @(negedge clk);
    check_seq("t5", 1, 8'h40);
    check("t5_intr_cnt", WW'(intr_cnt), WW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
